// File: rtl/tdm_mux_pkg.sv
// Shared defaults and width helpers for the tdm_mux time-division multiplexer.
// The defaults reproduce the original two-input, single-bit, one-cycle-dwell mux.
package tdm_mux_pkg;

  localparam int DEF_WIDTH    = 1;
  localparam int DEF_CHANNELS = 2;
  localparam int DEF_DWELL    = 1;

  // Bits needed to index n items, never less than one so counters stay legal.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int DEF_SEL_W = clog2_min1(DEF_CHANNELS);
  localparam int DEF_CNT_W = clog2_min1(DEF_DWELL);

endpackage

// File: rtl/tdm_mux_next.sv
// Round-robin finder: first enabled channel after ptr in cyclic order, plus lowest enabled index.
// Purely combinational; an empty mask yields index 0 with any_enabled low.
module tdm_mux_next
  import tdm_mux_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = clog2_min1(CHANNELS)
) (
  input  logic [SEL_W-1:0]    ptr,
  input  logic [CHANNELS-1:0] mask,
  output logic [SEL_W-1:0]    next_idx,
  output logic                any_enabled,
  output logic [SEL_W-1:0]    lowest_idx
);

  logic [SEL_W-1:0] above_idx;
  logic             above_found;

  // Descending scan so the last hit is the lowest qualifying index.
  always_comb begin
    lowest_idx  = '0;
    above_idx   = '0;
    above_found = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest_idx = SEL_W'(i);
        if (i > int'(ptr)) begin
          above_idx   = SEL_W'(i);
          above_found = 1'b1;
        end
      end
    end
  end

  assign any_enabled = |mask;
  assign next_idx    = above_found ? above_idx : lowest_idx;

endmodule

// File: rtl/tdm_mux.sv
// Round-robin TDM mux: each enabled channel owns dout for DWELL cycles; one-cycle registered latency.
// en low freezes the sequencer and drops valid; TDM_MUX_SAMPLE_HOLD_EN latches din once per slot.
module tdm_mux
  import tdm_mux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DWELL    = DEF_DWELL,
  localparam int SEL_W   = clog2_min1(CHANNELS),
  localparam int CNT_W   = clog2_min1(DWELL)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [CHANNELS-1:0]       mask,
  output logic [WIDTH-1:0]          dout,
  output logic [SEL_W-1:0]          sel,
  output logic                      valid,
  output logic                      frame_start
);

  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] next_idx;
  logic [SEL_W-1:0] lowest_idx;
  logic             any_enabled;
  logic [WIDTH-1:0] ch [CHANNELS];
  logic             cnt_last;
  logic             slot_first;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
    assign ch[k] = din[k*WIDTH +: WIDTH];
  end

  tdm_mux_next #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_next (
    .ptr         (ptr),
    .mask        (mask),
    .next_idx    (next_idx),
    .any_enabled (any_enabled),
    .lowest_idx  (lowest_idx)
  );

  assign cnt_last   = (cnt == CNT_W'(DWELL - 1));
  assign slot_first = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      cnt         <= '0;
      dout        <= '0;
      sel         <= '0;
      valid       <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      if (cnt_last) begin
        cnt <= '0;
        ptr <= any_enabled ? next_idx : '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      sel         <= ptr;
      valid       <= mask[ptr];
      frame_start <= slot_first && mask[ptr] && (ptr == lowest_idx);
`ifdef TDM_MUX_SAMPLE_HOLD_EN
      if (slot_first) dout <= ch[ptr];
`else
      dout <= ch[ptr];
`endif
    end else begin
      valid       <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdm_mux.sv
// Randomized scoreboard bench for tdm_mux (CHANNELS=4, WIDTH=8, DWELL=3) against a cyclic-search model.
module tb_tdm_mux;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int DW = 3;

  typedef struct packed {
    logic [W-1:0] dout;
    logic [1:0]   sel;
    logic         valid;
    logic         fs;
  } obs_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [CH*W-1:0] din;
  logic [CH-1:0]   mask;
  logic [W-1:0]    dout;
  logic [1:0]      sel;
  logic            valid;
  logic            frame_start;

  tdm_mux #(.WIDTH(W), .CHANNELS(CH), .DWELL(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .din         (din),
    .mask        (mask),
    .dout        (dout),
    .sel         (sel),
    .valid       (valid),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  obs_t expq[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  bit   stim_done = 1'b0;

  // Reference state: current channel and cycles already spent in its slot.
  int   m_cur = 0;
  int   m_age = 0;
  obs_t m_out = '0;

  function automatic int first_enabled_after(int cur, logic [CH-1:0] m);
    for (int k = 1; k <= CH; k++) begin
      if (m[(cur + k) % CH]) return (cur + k) % CH;
    end
    return 0;
  endfunction

  function automatic int lowest_enabled(logic [CH-1:0] m);
    for (int k = 0; k < CH; k++) if (m[k]) return k;
    return -1;
  endfunction

  // Apply the inputs currently driven to the model, push the expected post-edge outputs.
  task automatic model_step();
    obs_t e;
    logic [W-1:0] chv;
    e = m_out;
    if (rst) begin
      e = '0;
      m_cur = 0;
      m_age = 0;
    end else if (en) begin
      chv     = din[m_cur*W +: W];
      e.sel   = 2'(m_cur);
      e.valid = mask[m_cur];
      e.fs    = (m_age == 0) && mask[m_cur] && (lowest_enabled(mask) == m_cur);
`ifdef TDM_MUX_SAMPLE_HOLD_EN
      if (m_age == 0) e.dout = chv;
`else
      e.dout = chv;
`endif
      m_age++;
      if (m_age == DW) begin
        m_age = 0;
        m_cur = first_enabled_after(m_cur, mask);
      end
    end else begin
      e.valid = 1'b0;
      e.fs    = 1'b0;
    end
    m_out = e;
    expq.push_back(e);
  endtask

  // Monitor: compares one expected entry per clock, sampled just after the edge.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = '{dout: dout, sel: sel, valid: valid, fs: frame_start};
        n_checks++;
        if (a !== e) begin
          n_fails++;
          $display("FAIL outputs t=%0t: got dout=%h sel=%0d valid=%b fs=%b, expected dout=%h sel=%0d valid=%b fs=%b",
                   $time, a.dout, a.sel, a.valid, a.fs, e.dout, e.sel, e.valid, e.fs);
        end
      end
    end
  end

  task automatic drive_cycle(input logic r, input logic e, input logic [CH-1:0] m,
                             input logic [CH*W-1:0] d);
    @(negedge clk);
    rst  = r;
    en   = e;
    mask = m;
    din  = d;
    model_step();
  endtask

  function automatic logic [CH*W-1:0] rand_din();
    return {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
  endfunction

  initial begin
    logic [CH*W-1:0] d;
    logic [CH-1:0]   m;
    logic [CH-1:0]   phase_masks [8];
    rst = 1'b1; en = 1'b0; mask = '0; din = '0;
    phase_masks[0] = 4'b1111;
    phase_masks[1] = 4'b1010;
    phase_masks[2] = 4'b0000;
    phase_masks[3] = 4'b0100;
    phase_masks[4] = 4'b0001;
    phase_masks[5] = 4'b0110;
    phase_masks[6] = 4'b1001;
    phase_masks[7] = 4'b1111;

    // Reset held two cycles with arbitrary data.
    drive_cycle(1'b1, 1'b1, 4'b1111, rand_din());
    drive_cycle(1'b1, 1'b0, 4'b1111, rand_din());

    // Steady round-robin with fixed data.
    for (int i = 0; i < 30; i++)
      drive_cycle(1'b0, 1'b1, 4'b1111, {8'h44, 8'h33, 8'h22, 8'h11});

    // Freeze mid-slot, then resume.
    drive_cycle(1'b0, 1'b1, 4'b1111, {8'h44, 8'h33, 8'h22, 8'h11});
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b0, 1'b0, 4'b1111, rand_din());
    for (int i = 0; i < 8; i++)
      drive_cycle(1'b0, 1'b1, 4'b1111, {8'h44, 8'h33, 8'h22, 8'h11});

    // Mask phases, each starting from reset, with random data churn, freezes and mask flips.
    for (int p = 0; p < 8; p++) begin
      d = rand_din();
      m = phase_masks[p];
      drive_cycle(1'b1, 1'b0, m, d);
      for (int i = 0; i < 80; i++) begin
        if ($urandom_range(0, 99) < 35) d = rand_din();
        if (p >= 6 && $urandom_range(0, 99) < 5) m = 4'($urandom);
        drive_cycle((p == 7) && ($urandom_range(0, 99) < 3), $urandom_range(0, 99) < 80, m, d);
      end
    end

    // Fully random tail.
    for (int i = 0; i < 300; i++)
      drive_cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85,
                  4'($urandom), ($urandom_range(0, 1) == 1) ? rand_din() : din);

    @(posedge clk);
    #3;
    n_checks++;
    if (expq.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", expq.size());
    end
    stim_done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    if (!stim_done) begin
      $display("FAIL timeout: bench did not finish within time limit");
      $fatal(1, "timeout");
    end
  end

endmodule
